led_pattern_gen: RTL

//   Multi-channel LED driver; successor to the single fixed-rate blinker.

---
 rtl/led_pattern_gen.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler and PWM counter,
// with one led_chan instance per LEDG pin (OFF / ON / BLINK / PWM).

module led_chan #(
  parameter int         PERIOD_W       = 16,
  parameter int         PWM_BITS       = 8,
  parameter int         DEFAULT_PERIOD = 500,
  parameter logic [1:0] RST_MODE       = 2'd0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                sync_i,
  input  logic                we_i,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o
);
  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PWM = 2'd3;

  logic [1:0]          mode_q,   mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PWM_BITS-1:0] duty_q,   duty_d;
  logic [PERIOD_W-1:0] phase_q,  phase_d;
  logic                blink_q,  blink_d;
  logic                led_q,    led_d;
  logic [PERIOD_W-1:0] last_phase;

  // A half-period of 0 behaves as 1, so the last phase is 0 in that case.
  assign last_phase = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  // Next-state: a write beats SYNC, SYNC beats a tick, tick only advances BLINK.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    phase_d  = phase_q;
    blink_d  = blink_q;
    if (we_i) begin
      mode_d   = mode_i;
      period_d = period_i;
      duty_d   = duty_i;
      phase_d  = '0;
      blink_d  = 1'b1;
    end else if (sync_i) begin
      phase_d  = '0;
      blink_d  = 1'b1;
    end else if (tick_i && mode_q == M_BLINK) begin
      if (phase_q == last_phase) begin
        phase_d = '0;
        blink_d = ~blink_q;
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end
  end

  // LED drive is computed from the current state and registered.
  always_comb begin
    led_d = 1'b0;
    case (mode_q)
      M_OFF:   led_d = 1'b0;
      M_ON:    led_d = 1'b1;
      M_BLINK: led_d = blink_q;
      M_PWM:   led_d = (pwm_cnt_i < duty_q);
      default: led_d = 1'b0;
    endcase
  end

  // Channel state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mode_q   <= RST_MODE;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
      duty_q   <= '0;
      phase_q  <= '0;
      blink_q  <= 1'b1;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;
endmodule

module led_pattern_gen #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int NUM_LEDS       = 8,
  parameter int PERIOD_W       = 16,
  parameter int PWM_BITS       = 8,
  parameter int DEFAULT_PERIOD = 500,
  parameter int BOOT_BLINK     = 1,
  localparam int SEL_W         = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                CFG_WE,
  input  logic [SEL_W-1:0]    CFG_SEL,
  input  logic [1:0]          CFG_MODE,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
  input  logic [PWM_BITS-1:0] CFG_DUTY,
  input  logic                SYNC,
  output logic [NUM_LEDS-1:0] LEDG,
  output logic                TICK
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic                tick_q;
  logic                tick_evt;

  // The edge that wraps the prescaler is the tick edge for all channels.
  assign tick_evt = (presc_q == PRE_W'(DIV - 1));

  // Shared counters: prescaler wraps at DIV-1, PWM counter free-runs; SYNC clears both.
  always_comb begin
    presc_d = tick_evt ? '0 : presc_q + PRE_W'(1);
    pwm_d   = pwm_q + PWM_BITS'(1);
    if (SYNC) begin
      presc_d = '0;
      pwm_d   = '0;
    end
  end

  // Shared counter registers and the registered TICK pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      presc_q <= '0;
      pwm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_evt;
    end
  end

  assign TICK = tick_q;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_chan #(
      .PERIOD_W       (PERIOD_W),
      .PWM_BITS       (PWM_BITS),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .RST_MODE       ((BOOT_BLINK != 0 && i == 0) ? 2'd2 : 2'd0)
    ) u_chan (
      .clk_i     (CLOCK_50),
      .rst_ni    (RESET_N),
      .tick_i    (tick_evt),
      .sync_i    (SYNC),
      .we_i      (CFG_WE && (CFG_SEL == SEL_W'(i))),
      .mode_i    (CFG_MODE),
      .period_i  (CFG_PERIOD),
      .duty_i    (CFG_DUTY),
      .pwm_cnt_i (pwm_q),
      .led_o     (LEDG[i])
    );
  end
endmodule
